// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-access and memory-side signals of the unified memory port arbiter.
// slave is the arbiter's view; master is the view of the cores plus memory around it.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;

   logic        ma_req;
   logic        ma_we;
   logic [2:0]  ma_funct3;
   logic [31:0] ma_addr;
   logic [31:0] ma_wdata;
   logic        ma_ready;
   logic [31:0] ma_rdata;
   logic        ma_misaligned;

   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_ready, if_rdata,
      input  ma_req, ma_we, ma_funct3, ma_addr, ma_wdata,
      output ma_ready, ma_rdata, ma_misaligned,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_ready, if_rdata,
      output ma_req, ma_we, ma_funct3, ma_addr, ma_wdata,
      input  ma_ready, ma_rdata, ma_misaligned,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the memory-access stage: MA priority with a bounded
// fetch starvation count, plus load/store lane handling and misalignment rejection for MA.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMa, StResp} state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

   localparam logic [2:0] F3Byte   = 3'b000;
   localparam logic [2:0] F3Half   = 3'b001;
   localparam logic [2:0] F3Word   = 3'b010;
   localparam logic [2:0] F3ByteU  = 3'b100;
   localparam logic [2:0] F3HalfU  = 3'b101;

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;

   logic        if_ready_q, if_ready_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        ma_ready_q, ma_ready_d;
   logic [31:0] ma_rdata_q, ma_rdata_d;
   logic        ma_mis_q, ma_mis_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        ma_fault;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_shift;
   logic [31:0] ld_data;
   logic        grant_ma;
   logic [1:0]  ma_off;

   assign ma_off = bus.ma_addr[1:0];

   // Request-side decode, evaluated on the live MA inputs at grant time.
   always_comb begin
      ma_fault = 1'b0;
      st_be    = 4'b1111;
      st_wdata = bus.ma_wdata;
      if (bus.ma_we) begin
         case (bus.ma_funct3)
            F3Byte: begin
               st_be    = 4'b0001 << ma_off;
               st_wdata = {4{bus.ma_wdata[7:0]}};
            end
            F3Half: begin
               st_be    = 4'b0011 << ma_off;
               st_wdata = {2{bus.ma_wdata[15:0]}};
               ma_fault = ma_off[0];
            end
            F3Word:  ma_fault = (ma_off != 2'b00);
            default: ma_fault = 1'b1;
         endcase
      end else begin
         case (bus.ma_funct3)
            F3Byte, F3ByteU: ma_fault = 1'b0;
            F3Half, F3HalfU: ma_fault = ma_off[0];
            F3Word:          ma_fault = (ma_off != 2'b00);
            default:         ma_fault = 1'b1;
         endcase
      end
   end

   // Load extraction uses the size and offset latched at grant.
   always_comb begin
      ld_shift = bus.mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         F3Byte:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         F3ByteU: ld_data = {24'h0, ld_shift[7:0]};
         F3Half:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         F3HalfU: ld_data = {16'h0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   assign grant_ma = bus.ma_req && !(bus.if_req && (starve_q == StarveMax));

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      f3_d        = f3_q;
      off_d       = off_q;
      if_ready_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      ma_ready_d  = 1'b0;
      ma_rdata_d  = ma_rdata_q;
      ma_mis_d    = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         StIdle: begin
            if (grant_ma) begin
               if (!bus.if_req) begin
                  starve_d = 4'd0;
               end else if (starve_q != StarveMax) begin
                  starve_d = starve_q + 4'd1;
               end
               if (ma_fault) begin
                  // Rejected accesses skip the memory cycle entirely.
                  state_d    = StResp;
                  ma_ready_d = 1'b1;
                  ma_mis_d   = 1'b1;
                  ma_rdata_d = 32'h0;
               end else begin
                  state_d     = StBusyMa;
                  f3_d        = bus.ma_funct3;
                  off_d       = ma_off;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.ma_we;
                  mem_be_d    = bus.ma_we ? st_be : 4'b1111;
                  mem_addr_d  = {bus.ma_addr[31:2], 2'b00};
                  mem_wdata_d = bus.ma_we ? st_wdata : 32'h0;
               end
            end else if (bus.if_req) begin
               starve_d    = 4'd0;
               state_d     = StBusyIf;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_be_d    = 4'b1111;
               mem_addr_d  = {bus.if_addr[31:2], 2'b00};
               mem_wdata_d = 32'h0;
            end
         end
         StBusyIf: begin
            if (bus.mem_ack) begin
               state_d    = StResp;
               mem_req_d  = 1'b0;
               if_ready_d = 1'b1;
               if_rdata_d = bus.mem_rdata;
            end
         end
         StBusyMa: begin
            if (bus.mem_ack) begin
               state_d    = StResp;
               mem_req_d  = 1'b0;
               ma_ready_d = 1'b1;
               ma_rdata_d = mem_we_q ? 32'h0 : ld_data;
            end
         end
         StResp: begin
            // No arbitration here so requesters can drop or renew their request.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         starve_q    <= 4'd0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         if_ready_q  <= 1'b0;
         if_rdata_q  <= 32'h0;
         ma_ready_q  <= 1'b0;
         ma_rdata_q  <= 32'h0;
         ma_mis_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         if_ready_q  <= if_ready_d;
         if_rdata_q  <= if_rdata_d;
         ma_ready_q  <= ma_ready_d;
         ma_rdata_q  <= ma_rdata_d;
         ma_mis_q    <= ma_mis_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.if_ready      = if_ready_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.ma_ready      = ma_ready_q;
   assign bus.ma_rdata      = ma_rdata_q;
   assign bus.ma_misaligned = ma_mis_q;
   assign bus.mem_req       = mem_req_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_be        = mem_be_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Values captured by run_ma for the calling test to compare.
   logic        c_ok;
   logic        c_saw_req;
   int          c_lat;
   logic [31:0] c_addr;
   logic [3:0]  c_be;
   logic        c_we;
   logic [31:0] c_wdata;
   logic [31:0] c_rdata;
   logic        c_mis;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.ma_req    = 1'b0;
      bus.ma_we     = 1'b0;
      bus.ma_funct3 = 3'b000;
      bus.ma_addr   = 32'h0;
      bus.ma_wdata  = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
   endtask

   // Issues one MA request, acks the first memory cycle, waits for ma_ready (bounded).
   task automatic run_ma(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
      bus.ma_req    = 1'b1;
      bus.ma_we     = we;
      bus.ma_funct3 = f3;
      bus.ma_addr   = addr;
      bus.ma_wdata  = wdata;
      bus.mem_rdata = rdata;
      c_ok      = 1'b0;
      c_saw_req = 1'b0;
      c_lat     = 0;
      for (int i = 0; i < 10 && !c_ok; i++) begin
         tick();
         if (bus.mem_req) begin
            c_saw_req = 1'b1;
            c_addr    = bus.mem_addr;
            c_be      = bus.mem_be;
            c_we      = bus.mem_we;
            c_wdata   = bus.mem_wdata;
            bus.mem_ack = 1'b1;
         end else begin
            bus.mem_ack = 1'b0;
         end
         if (bus.ma_ready) begin
            c_ok    = 1'b1;
            c_lat   = i + 1;
            c_rdata = bus.ma_rdata;
            c_mis   = bus.ma_misaligned;
         end
      end
      bus.ma_req  = 1'b0;
      bus.mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst           = 1'b1;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h40;
      bus.ma_req    = 1'b1;
      bus.ma_funct3 = 3'b010;
      bus.ma_addr   = 32'h10;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1122_3344;
      tick();
      tick();
      n_checks++;
      if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.ma_ready, bus.ma_misaligned} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000", {bus.mem_req, bus.mem_we,
                  bus.if_ready, bus.ma_ready, bus.ma_misaligned});
      end
      n_checks++;
      if ({bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ma_rdata} !== 132'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {bus.mem_be, bus.mem_addr,
                  bus.mem_wdata, bus.if_rdata, bus.ma_rdata});
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL reset_first_grant: got req=%b addr=%h expected req=1 addr=00000010",
                  bus.mem_req, bus.mem_addr);
      end
      tick();
      n_checks++;
      if (bus.ma_ready !== 1'b1 || bus.ma_rdata !== 32'h1122_3344) begin
         n_fail++;
         $display("FAIL reset_ma_ready_at_2: got ready=%b rdata=%h expected 1 11223344",
                  bus.ma_ready, bus.ma_rdata);
      end
      bus.ma_req = 1'b0;
      tick();
      n_checks++;
      if (bus.ma_ready !== 1'b0 || bus.if_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulse_width: got ma_ready=%b if_ready=%b expected 0 0",
                  bus.ma_ready, bus.if_ready);
      end
      tick();
      tick();
      n_checks++;
      if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h1122_3344) begin
         n_fail++;
         $display("FAIL reset_if_ready_at_5: got ready=%b rdata=%h expected 1 11223344",
                  bus.if_ready, bus.if_rdata);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_load();
      run_ma(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234);
      n_checks++;
      if (c_ok !== 1'b1 || c_lat != 2) begin
         n_fail++;
         $display("FAIL lb_latency: got ok=%b lat=%0d expected ok=1 lat=2", c_ok, c_lat);
      end
      n_checks++;
      if (c_addr !== 32'h100 || c_be !== 4'b1111 || c_we !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_bus: got addr=%h be=%b we=%b expected 00000100 1111 0",
                  c_addr, c_be, c_we);
      end
      n_checks++;
      if (c_rdata !== 32'hFFFF_FF80 || c_mis !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_data: got %h mis=%b expected ffffff80 mis=0", c_rdata, c_mis);
      end
      run_ma(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234);
      n_checks++;
      if (c_rdata !== 32'h0000_0080) begin
         n_fail++;
         $display("FAIL lbu_data: got %h expected 00000080", c_rdata);
      end
      run_ma(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234);
      n_checks++;
      if (c_rdata !== 32'hFFFF_80FF) begin
         n_fail++;
         $display("FAIL lh_data: got %h expected ffff80ff", c_rdata);
      end
      run_ma(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234);
      n_checks++;
      if (c_rdata !== 32'h0000_80FF) begin
         n_fail++;
         $display("FAIL lhu_data: got %h expected 000080ff", c_rdata);
      end
      run_ma(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF_1234);
      n_checks++;
      if (c_rdata !== 32'h0000_0012) begin
         n_fail++;
         $display("FAIL lb_lane1_data: got %h expected 00000012", c_rdata);
      end
      run_ma(1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF_1234);
      n_checks++;
      if (c_rdata !== 32'h80FF_1234) begin
         n_fail++;
         $display("FAIL lw_data: got %h expected 80ff1234", c_rdata);
      end
   endtask

   task automatic test_store();
      run_ma(1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h5555_5555);
      n_checks++;
      if (c_addr !== 32'h200 || c_be !== 4'b1100 || c_we !== 1'b1) begin
         n_fail++;
         $display("FAIL sh_bus: got addr=%h be=%b we=%b expected 00000200 1100 1",
                  c_addr, c_be, c_we);
      end
      n_checks++;
      if (c_wdata !== 32'hBEEF_BEEF || c_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL sh_data: got wdata=%h rdata=%h expected beefbeef 00000000",
                  c_wdata, c_rdata);
      end
      run_ma(1'b1, 3'b000, 32'h201, 32'h1234_5678, 32'h0);
      n_checks++;
      if (c_be !== 4'b0010 || c_wdata !== 32'h7878_7878) begin
         n_fail++;
         $display("FAIL sb_lane1: got be=%b wdata=%h expected 0010 78787878", c_be, c_wdata);
      end
      run_ma(1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h0);
      n_checks++;
      if (c_addr !== 32'h204 || c_be !== 4'b1111 || c_wdata !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL sw_bus: got addr=%h be=%b wdata=%h expected 00000204 1111 cafef00d",
                  c_addr, c_be, c_wdata);
      end
   endtask

   task automatic test_misaligned();
      run_ma(1'b0, 3'b010, 32'h305, 32'h0, 32'h1234_5678);
      n_checks++;
      if (c_ok !== 1'b1 || c_lat != 1 || c_saw_req !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_mis_timing: got ok=%b lat=%0d saw_req=%b expected 1 1 0",
                  c_ok, c_lat, c_saw_req);
      end
      n_checks++;
      if (c_mis !== 1'b1 || c_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL lw_mis_flag: got mis=%b rdata=%h expected 1 00000000", c_mis, c_rdata);
      end
      run_ma(1'b0, 3'b101, 32'h101, 32'h0, 32'h0);
      n_checks++;
      if (c_mis !== 1'b1 || c_saw_req !== 1'b0) begin
         n_fail++;
         $display("FAIL lhu_mis: got mis=%b saw_req=%b expected 1 0", c_mis, c_saw_req);
      end
      run_ma(1'b1, 3'b011, 32'h100, 32'h0, 32'h0);
      n_checks++;
      if (c_mis !== 1'b1 || c_saw_req !== 1'b0) begin
         n_fail++;
         $display("FAIL store_f3_011: got mis=%b saw_req=%b expected 1 0", c_mis, c_saw_req);
      end
      run_ma(1'b0, 3'b110, 32'h100, 32'h0, 32'h0);
      n_checks++;
      if (c_mis !== 1'b1 || c_saw_req !== 1'b0) begin
         n_fail++;
         $display("FAIL load_f3_110: got mis=%b saw_req=%b expected 1 0", c_mis, c_saw_req);
      end
      run_ma(1'b1, 3'b000, 32'h103, 32'hAB, 32'h0);
      n_checks++;
      if (c_mis !== 1'b0 || c_be !== 4'b1000 || c_wdata !== 32'hABAB_ABAB) begin
         n_fail++;
         $display("FAIL sb_lane3: got mis=%b be=%b wdata=%h expected 0 1000 abababab",
                  c_mis, c_be, c_wdata);
      end
   endtask

   task automatic test_starvation();
      logic [9:0] seq;
      int         n_done;
      int         last_cyc;
      seq      = 10'b0;
      n_done   = 0;
      last_cyc = 0;
      bus.ma_req    = 1'b1;
      bus.ma_we     = 1'b0;
      bus.ma_funct3 = 3'b010;
      bus.ma_addr   = 32'h10;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h80;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h0BAD_CAFE;
      for (int cyc = 1; cyc <= 60 && n_done < 10; cyc++) begin
         tick();
         if (bus.ma_ready || bus.if_ready) begin
            seq      = {seq[8:0], bus.if_ready};
            n_done   = n_done + 1;
            last_cyc = cyc;
         end
      end
      idle_inputs();
      tick();
      n_checks++;
      if (n_done != 10) begin
         n_fail++;
         $display("FAIL starve_count: got %0d completions expected 10", n_done);
      end
      n_checks++;
      if (seq !== 10'b0000100001) begin
         n_fail++;
         $display("FAIL starve_order: got %b expected 0000100001 (1=fetch)", seq);
      end
      n_checks++;
      if (last_cyc != 29) begin
         n_fail++;
         $display("FAIL starve_spacing: got last completion at %0d expected 29", last_cyc);
      end
   endtask

   task automatic test_spurious_ack();
      logic any_ready;
      any_ready   = 1'b0;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         any_ready = any_ready | bus.ma_ready | bus.if_ready | bus.mem_req;
      end
      bus.mem_ack = 1'b0;
      n_checks++;
      if (any_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ack_ignored: got activity=%b expected 0", any_ready);
      end
   endtask

   task automatic test_reset_abort();
      logic saw_if_ready;
      saw_if_ready  = 1'b0;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h40;
      bus.mem_rdata = 32'h0000_0013;
      tick();
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_be !== 4'b1111) begin
         n_fail++;
         $display("FAIL fetch_bus: got req=%b addr=%h be=%b expected 1 00000040 1111",
                  bus.mem_req, bus.mem_addr, bus.mem_be);
      end
      tick();
      tick();
      saw_if_ready = saw_if_ready | bus.if_ready;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async_drop: got mem_req=%b expected 0", bus.mem_req);
      end
      tick();
      saw_if_ready = saw_if_ready | bus.if_ready;
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
         n_fail++;
         $display("FAIL abort_restart: got req=%b addr=%h expected 1 00000040",
                  bus.mem_req, bus.mem_addr);
      end
      saw_if_ready = saw_if_ready | bus.if_ready;
      tick();
      saw_if_ready = saw_if_ready | bus.if_ready;
      bus.mem_ack = 1'b1;
      tick();
      n_checks++;
      if (saw_if_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_ready: got early if_ready=%b expected 0", saw_if_ready);
      end
      n_checks++;
      if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h13 || bus.mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_complete: got ready=%b rdata=%h req=%b expected 1 00000013 0",
                  bus.if_ready, bus.if_rdata, bus.mem_req);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      test_reset();
      test_load();
      test_store();
      test_misaligned();
      test_spurious_ack();
      test_starvation();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the memory-access stage (MA).
- Arbitrates with MA priority plus a fetch anti-starvation bound.
- Sequences each transfer through a small FSM.
- For MA: decodes the load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW) into byte enables, store-lane replication, load extraction/sign-extension and misalignment detection.

Parameters:
- STARVE_MAX, 4, maximum consecutive MA grants while if_req is pending before IF is forced to win (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_ready  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetched instruction; valid while if_ready=1.
- ma_req  in  1  data request; held with all ma_* inputs stable until ma_ready.
- ma_we  in  1  1 = store (funct3 per funct3SType_e), 0 = load (funct3ITypeLOAD_e).
- ma_funct3  in  3  access size/sign.
- ma_addr  in  32  byte address.
- ma_wdata  in  32  store data, right-aligned.
- ma_ready  out  1  one-cycle completion pulse.
- ma_rdata  out  32  extended load data; 0 for stores and on fault.
- ma_misaligned  out  1  qualifies ma_ready: access rejected, no memory cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables; bit k = byte lane k = bits [8k+7:8k] (little-endian).
- mem_addr  out  32  word address; [1:0] always 0.
- mem_wdata  out  32  lane-positioned store data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_MA, RESP. All outputs are registered.
- Reset: state=IDLE, starve counter=0, every output 0. Reset mid-transfer aborts it; mem_req drops asynchronously; no ready pulse is issued.
- Arbitration happens only in IDLE:
  - MA wins if ma_req=1, unless if_req=1 and counter==STARVE_MAX, in which case IF wins.
  - An IF grant clears the counter.
  - An MA grant with if_req=1 increments the counter (saturating). An MA grant with if_req=0 clears it.
- Valid IF/MA grant in IDLE at cycle N:
  - BUSY_x from N+1, with mem_req=1 and mem_addr/we/be/wdata constant until mem_ack.
  - mem_ack sampled at cycle M≥N+1.
  - At M+1: state RESP, ready pulse and rdata driven, mem_req=0.
  - At M+2: IDLE.
  - Minimum req→ready latency is 2 cycles, with mem_ack on the first mem_req cycle. Back-to-back grant spacing is 3 cycles.
- RESP never arbitrates, so the requester has one cycle to drop or renew its request.
- mem_ack while mem_req=0 is ignored.
- Fetch transfer: mem_we=0, mem_be=4'b1111, if_rdata=mem_rdata.
- MA fault: misaligned halfword (funct3 001/101 load or 001 store with addr[0]=1), misaligned word (010 with addr[1:0]≠0), or undefined funct3 (load 011/110/111, store ≥011).
  - Granted in IDLE at N, the fault goes straight to RESP at N+1 with ma_ready=1, ma_misaligned=1, ma_rdata=0, and no mem_req.
  - A fault grant counts as an MA grant for the starve counter.
- Store lanes, with a=addr[1:0]:
  - SB: be=4'b0001<<a, wdata={4{d[7:0]}}.
  - SH: be=4'b0011<<a, wdata={2{d[15:0]}}.
  - SW: be=4'b1111, wdata=d.
- Loads: mem_be=4'b1111. Let s=mem_rdata>>(8·a).
  - LB: sign-extend s[7:0].
  - LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0].
  - LHU: zero-extend s[15:0].
  - LW: s.
- Simultaneous requests with counter<STARVE_MAX: MA is served and IF waits in the queue. With STARVE_MAX=4, IF is guaranteed a grant after at most 4 MA grants.

Test Plan:
- Reset with both requests high, then release → all outputs 0 for the reset cycle. With mem_ack tied 1, ma_ready at release+2; if_ready 3 cycles after ma_ready.
- LB at addr 0x103, mem_rdata=0x80FF_1234 → mem_addr=0x100, be=1111, ma_rdata=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH at addr 0x202, wdata=0xDEAD_BEEF → mem_addr=0x200, be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1.
- LW at addr 0x305 → ma_ready=1 and ma_misaligned=1 one cycle after grant, mem_req never asserted, ma_rdata=0.
- ma_req held continuously with if_req=1, STARVE_MAX=4 → exactly 4 MA completions, then one IF completion, then the counter restarts.
- Fetch at 0x40 with mem_ack delayed 5 cycles, rst pulsed at wait cycle 3 → mem_req falls with rst, no if_ready, state IDLE, fetch restarts cleanly after release.
